// File: rtl/prince_iter_core_if.sv
`default_nettype none
// ============================================================================
// Module   : prince_iter_core_if
// Purpose  : Block-in / result-out handshake bundle of the iterative PRINCE core.
// Revision : 1.0
// ============================================================================
interface prince_iter_core_if;
   logic          in_valid;
   logic          in_ready;
   logic          dec;
   logic [63:0]   din;
   logic [127:0]  key;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   dout;
   logic          busy;

   // master: producer/consumer side of the core
   modport master (
      output in_valid, dec, din, key, out_ready,
      input  in_ready, out_valid, dout, busy
   );

   // slave: the cipher core itself
   modport slave (
      input  in_valid, dec, din, key, out_ready,
      output in_ready, out_valid, dout, busy
   );
endinterface
`default_nettype wire

// File: rtl/prince_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : prince_iter_core
// Purpose  : Iterative PRINCE encrypt/decrypt, one round per clock, shared
//            round datapath sequenced by a 4-bit round counter.
// Revision : 1.0
// ============================================================================
module prince_iter_core (
   input  wire logic         clk,
   input  wire logic         rst,
   prince_iter_core_if.slave bus
);

   localparam logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd;
   localparam logic [63:0] RC11  = 64'hc0ac29b7c97c50dd;

   localparam logic [3:0] SBOX  [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                         4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
   localparam logic [3:0] ISBOX [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                         4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
   localparam logic [3:0] SR_P  [16] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
                                         4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   // ------------------------------------------------------------------------
   // Round-function building blocks
   // ------------------------------------------------------------------------
   function automatic logic [63:0] round_const(input logic [3:0] idx);
      logic [63:0] c;
      case (idx)
         4'd1:    c = 64'h13198a2e03707344;
         4'd2:    c = 64'ha4093822299f31d0;
         4'd3:    c = 64'h082efa98ec4e6c89;
         4'd4:    c = 64'h452821e638d01377;
         4'd5:    c = 64'hbe5466cf34e90c6c;
         4'd6:    c = 64'h7ef84f78fd955cb1;
         4'd7:    c = 64'h85840851f1ac43aa;
         4'd8:    c = 64'hc882d32f25323c54;
         4'd9:    c = 64'h64a51195e0e3610d;
         4'd10:   c = 64'hd3b5a399ca0c2399;
         4'd11:   c = RC11;
         default: c = 64'h0;
      endcase
      return c;
   endfunction

   function automatic logic [63:0] sub_layer(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         y[4*i +: 4] = inv ? ISBOX[x[4*i +: 4]] : SBOX[x[4*i +: 4]];
      end
      return y;
   endfunction

   function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         if (inv) y[63 - 4*int'(SR_P[i]) -: 4] = x[63 - 4*i -: 4];
         else     y[63 - 4*i -: 4]             = x[63 - 4*int'(SR_P[i]) -: 4];
      end
      return y;
   endfunction

   // M' = diag(M0^, M1^, M1^, M0^) over 16-bit slices, MSB slice first.
   // Within a slice, output bit c of nibble j is the XOR of bit c of the
   // three input nibbles k for which (j + k + s) mod 4 != c (s = 1 for M1^).
   function automatic logic [63:0] mprime(input logic [63:0] x);
      logic [63:0] y;
      logic        p;
      int          s;
      y = '0;
      for (int h = 0; h < 4; h++) begin
         s = (h == 1 || h == 2) ? 1 : 0;
         for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 4; c++) begin
               p = 1'b0;
               for (int k = 0; k < 4; k++) begin
                  if (((j + k + s) % 4) != c) p = p ^ x[63 - 16*h - 4*k - c];
               end
               y[63 - 16*h - 4*j - c] = p;
            end
         end
      end
      return y;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   fsm_t        fsm_q;
   logic [3:0]  rnd_q;
   logic [63:0] blk_q;
   logic [63:0] blk_d;
   logic [63:0] kw_out_q;
   logic [63:0] k1e_q;
   logic        out_valid_q;
   logic        busy_q;

   logic [63:0] k0;
   logic [63:0] k1;
   logic [63:0] k0_rot;
   logic [63:0] kw_in_d;
   logic [63:0] kw_out_d;
   logic [63:0] k1e_d;

   logic [3:0]  rc_idx;
   logic [63:0] rc_val;
   logic [63:0] m_in;
   logic [63:0] m_out;

   // Decryption is the same datapath with swapped whitening keys and k1^alpha.
   assign k0       = bus.key[127:64];
   assign k1       = bus.key[63:0];
   assign k0_rot   = {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
   assign kw_in_d  = bus.dec ? k0_rot : k0;
   assign kw_out_d = bus.dec ? k0 : k0_rot;
   assign k1e_d    = bus.dec ? (k1 ^ ALPHA) : k1;

   // One M' instance serves forward, middle and inverse rounds.
   always_comb begin
      rc_idx = (rnd_q <= 4'd6) ? rnd_q : (rnd_q - 4'd1);
      rc_val = round_const(rc_idx);
      m_in   = (rnd_q <= 4'd6) ? sub_layer(blk_q, 1'b0)
                               : shift_rows(blk_q ^ rc_val ^ k1e_q, 1'b1);
      m_out  = mprime(m_in);
      if (rnd_q <= 4'd5) begin
         blk_d = shift_rows(m_out, 1'b0) ^ rc_val ^ k1e_q;
      end else begin
         blk_d = sub_layer(m_out, 1'b1);
         if (rnd_q == 4'd11) blk_d = blk_d ^ RC11 ^ k1e_q ^ kw_out_q;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= ST_IDLE;
         rnd_q       <= 4'd0;
         blk_q       <= 64'd0;
         kw_out_q    <= 64'd0;
         k1e_q       <= 64'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (fsm_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  kw_out_q <= kw_out_d;
                  k1e_q    <= k1e_d;
                  blk_q    <= bus.din ^ kw_in_d ^ k1e_d;
                  rnd_q    <= 4'd1;
                  busy_q   <= 1'b1;
                  fsm_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               blk_q <= blk_d;
               if (rnd_q == 4'd11) begin
                  rnd_q       <= 4'd0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  fsm_q       <= ST_DONE;
               end else begin
                  rnd_q <= rnd_q + 4'd1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  fsm_q       <= ST_IDLE;
               end
            end
            default: begin
               fsm_q <= ST_IDLE;
            end
         endcase
      end
   end

   // in_ready is held low for the whole reset pulse, then tracks IDLE.
   assign bus.in_ready  = (fsm_q == ST_IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.dout      = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_prince_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_prince_iter_core
// Purpose  : Directed and randomized checks of prince_iter_core against
//            known vectors and a nibble-array PRINCE reference model.
// Revision : 1.0
// ============================================================================
module tb_prince_iter_core;

   localparam logic [3:0] SB  [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                       4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
   localparam logic [3:0] ISB [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                       4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
   localparam int         SRP [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
   // Column i of M0^ (LSB-first bit numbering of a 16-bit slice).
   localparam logic [15:0] M0C [16] = '{16'h0111, 16'h2220, 16'h4404, 16'h8088,
                                        16'h1011, 16'h0222, 16'h4440, 16'h8808,
                                        16'h1101, 16'h2022, 16'h0444, 16'h8880,
                                        16'h1110, 16'h2202, 16'h4044, 16'h0888};
   localparam logic [63:0] RC [12] = '{64'h0000000000000000, 64'h13198a2e03707344,
                                       64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
                                       64'h452821e638d01377, 64'hbe5466cf34e90c6c,
                                       64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa,
                                       64'hc882d32f25323c54, 64'h64a51195e0e3610d,
                                       64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd};

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   prince_iter_core_if bus ();

   prince_iter_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [63:0] f_sub(input logic [63:0] x, input logic inv);
      logic [63:0] y;
      logic [3:0]  n;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         n = x[4*i +: 4];
         y[4*i +: 4] = inv ? ISB[n] : SB[n];
      end
      return y;
   endfunction

   function automatic logic [63:0] f_sr(input logic [63:0] x, input logic inv);
      logic [3:0]  a [16];
      logic [3:0]  b [16];
      logic [63:0] y;
      for (int i = 0; i < 16; i++) a[i] = x[63 - 4*i -: 4];
      for (int i = 0; i < 16; i++) begin
         if (inv) b[SRP[i]] = a[i];
         else     b[i] = a[SRP[i]];
      end
      y = '0;
      for (int i = 0; i < 16; i++) y[63 - 4*i -: 4] = b[i];
      return y;
   endfunction

   function automatic logic [63:0] f_mp(input logic [63:0] x);
      logic [63:0] y;
      logic [15:0] col;
      y = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 16; i++) begin
            if (x[16*c + i]) begin
               col = (c == 1 || c == 2) ? M0C[(i + 12) % 16] : M0C[i];
               y[16*c +: 16] = y[16*c +: 16] ^ col;
            end
         end
      end
      return y;
   endfunction

   function automatic logic [63:0] ref_prince(input logic [63:0] d, input logic [127:0] k,
                                              input logic dc);
      logic [63:0] k0, k1, k0p, kin, kout, kk, s;
      k0   = k[127:64];
      k1   = k[63:0];
      k0p  = {k0[0], k0[63:1]} ^ (k0 >> 63);
      kin  = dc ? k0p : k0;
      kout = dc ? k0 : k0p;
      kk   = dc ? (k1 ^ RC[11]) : k1;
      s    = d ^ kin ^ kk ^ RC[0];
      for (int r = 1; r <= 5; r++) s = f_sr(f_mp(f_sub(s, 1'b0)), 1'b0) ^ RC[r] ^ kk;
      s = f_sub(f_mp(f_sub(s, 1'b0)), 1'b1);
      for (int r = 6; r <= 10; r++) s = f_sub(f_mp(f_sr(s ^ RC[r] ^ kk, 1'b1)), 1'b1);
      return s ^ RC[11] ^ kk ^ kout;
   endfunction

   // ---------------- checkers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Issue one block, scramble inputs while it runs, optionally stall the
   // result for `hold` cycles with a competing in_valid, then take it.
   task automatic run_block(input logic [63:0] d, input logic [127:0] k, input logic dc,
                            input logic [63:0] exp, input string tag, input int hold);
      int   cyc;
      logic stable;
      logic quiet;
      chkb({tag, ".in_ready"}, bus.in_ready, 1'b1);
      bus.din      = d;
      bus.key      = k;
      bus.dec      = dc;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chkb({tag, ".busy"}, bus.busy, 1'b1);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         bus.din = {$urandom, $urandom};
         bus.key = {$urandom, $urandom, $urandom, $urandom};
         bus.dec = 1'($urandom_range(1, 0));
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, ".latency"}, 64'(cyc), 64'd11);
      chk({tag, ".dout"}, bus.dout, exp);
      if (hold > 0) begin
         stable = 1'b1;
         quiet  = 1'b1;
         bus.in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.dout !== exp || bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
         end
         chkb({tag, ".hold_stable"}, stable, 1'b1);
         chkb({tag, ".hold_no_accept"}, quiet, 1'b1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chkb({tag, ".out_valid_drop"}, bus.out_valid, 1'b0);
      chkb({tag, ".not_accepted_in_done"}, bus.busy, 1'b0);
      chkb({tag, ".in_ready_after"}, bus.in_ready, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0]  d;
      logic [63:0]  e;
      logic [127:0] k;
      logic         seen;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.din       = '0;
      bus.key       = '0;
      bus.dec       = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chkb("reset.in_ready", bus.in_ready, 1'b0);
      chkb("reset.out_valid", bus.out_valid, 1'b0);
      chkb("reset.busy", bus.busy, 1'b0);
      chk("reset.dout", bus.dout, 64'h0);
      #3 rst = 1'b0;
      #1;
      chkb("release.in_ready", bus.in_ready, 1'b1);

      run_block(64'h0, 128'h0, 1'b0, 64'h818665aa0d02dfda, "enc_zero", 0);
      run_block(64'hffffffffffffffff, 128'h0, 1'b0, 64'h604ae6ca03c20ada, "enc_ones", 0);
      run_block(64'h0, {64'hffffffffffffffff, 64'h0}, 1'b0, 64'h9fb51935fc3df524, "enc_k0", 0);
      run_block(64'h0123456789abcdef, {64'h0, 64'hfedcba9876543210}, 1'b0,
                64'hae25ad3ca8fa9ccf, "enc_vec", 0);
      run_block(64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 1'b1,
                64'h0123456789abcdef, "dec_vec_hold", 20);

      // reset while the middle round is next
      bus.din      = 64'h0123456789abcdef;
      bus.key      = {$urandom, $urandom, $urandom, $urandom};
      bus.dec      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chkb("midrst.out_valid", bus.out_valid, 1'b0);
      chkb("midrst.busy", bus.busy, 1'b0);
      chkb("midrst.in_ready", bus.in_ready, 1'b0);
      chk("midrst.dout", bus.dout, 64'h0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      chkb("midrst.no_partial", seen, 1'b0);
      run_block(64'h0, {64'h0, 64'hffffffffffffffff}, 1'b0, 64'h78a54cbe737bb7ef, "post_rst", 0);

      // random encrypt/decrypt round trips against the model
      for (int n = 0; n < 6; n++) begin
         d = {$urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         e = ref_prince(d, k, 1'b0);
         run_block(d, k, 1'b0, e, "rnd_enc", int'($urandom_range(3, 0)));
         run_block(e, k, 1'b1, d, "rnd_dec", int'($urandom_range(3, 0)));
      end
      for (int n = 0; n < 4; n++) begin
         d = {$urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         run_block(d, k, 1'b1, ref_prince(d, k, 1'b1), "rnd_dec_only", 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
